wb_bus_arbiter: RTL
===================

// Module: wb_bus_arbiter
//
// PURPOSE
//   Shares the single 20-bit Wishbone bus (RAM/REG/CRTC/KBD/VRAM/VROM regions) between N masters:
//   the video fetch engine, the SPI bridge and the CPU bus adapter. Video gets priority; the other
//   masters are served round-robin. The whole cycle (CYC) is locked to one master. A watchdog ends
//   any transfer the slave never acknowledges, so no master can wedge the bus.
//
// PARAMETERS
//   NUM_MASTERS      3    requester count, 2..8; index 0 = video, 1 = SPI, 2 = CPU
//   PRIORITY_MASTER  0    index that wins arbitration whenever it requests; set NUM_MASTERS to disable
//   TIMEOUT_CYCLES   64   cycles of stb_o & !ack_i before error termination, 2..255
//
// PORTS
//   clock_i     in   1                 system clock, SYS_CLOCK_MHZ
//   reset_i     in   1                 synchronous, active-high
//   m_cyc_i     in   NUM_MASTERS       per-master CYC; a cycle is held while high
//   m_stb_i     in   NUM_MASTERS       per-master STB
//   m_we_i      in   NUM_MASTERS       per-master write enable
//   m_addr_i    in   NUM_MASTERS*WB_ADDR_WIDTH   per-master address, packed, master k at [k*20 +: 20]
//   m_dout_i    in   NUM_MASTERS*DATA_WIDTH      per-master write data, packed
//   m_din_o     out  DATA_WIDTH        read data, broadcast to all masters; valid only with own ack
//   m_ack_o     out  NUM_MASTERS       ack, only to the granted master
//   m_stall_o   out  NUM_MASTERS       high for every master not granted (and while arbitrating)
//   m_err_o     out  NUM_MASTERS       one-cycle timeout error to the granted master
//   cyc_o       out  1                 slave-side CYC
//   stb_o       out  1                 slave-side STB
//   we_o        out  1                 slave-side WE
//   addr_o      out  WB_ADDR_WIDTH     slave-side address
//   dout_o      out  DATA_WIDTH        slave-side write data
//   din_i       in   DATA_WIDTH        slave read data
//   ack_i       in   1                 slave ack
//   stall_i     in   1                 slave stall
//   grant_o     out  NUM_MASTERS       one-hot current grant, for debug and registers
//
// BEHAVIOUR
//   - Reset values
//     - state = IDLE; grant_o = 0; last = NUM_MASTERS-1, so master 0 wins first.
//     - Timeout counter = 0. cyc_o/stb_o/we_o = 0. m_ack_o/m_err_o = 0. m_stall_o = all ones.
//   - FSM IDLE -> BUSY -> (RELEASE) -> IDLE.
//     - IDLE
//       - If any m_cyc_i: register the grant.
//       - The grant goes to PRIORITY_MASTER if it requests. Otherwise it goes to the first requester
//         at index last+1 .. last+NUM_MASTERS, modulo NUM_MASTERS.
//       - Go to BUSY. Latency is 1 cycle from CYC to the grant; stall stays high in that cycle.
//     - BUSY
//       - Slave outputs = granted master's signals, combinational mux on registered grant_o.
//       - m_ack_o[g] = ack_i. m_stall_o[g] = stall_i.
//       - When m_cyc_i[g] falls: cyc_o drops in the same cycle (combinational), last <= g,
//         grant_o <= 0, and the FSM goes to IDLE. This gives 1 idle cycle between owners.
//     - RELEASE
//       - Entered on timeout. cyc_o = stb_o = 0 and acks are suppressed.
//       - Stay in RELEASE until m_cyc_i[g] = 0, then last <= g and go to IDLE.
//   - Priority does not preempt: PRIORITY_MASTER waits for the current owner to drop CYC.
//   - Watchdog
//     - In BUSY, the counter increments every cycle with stb_o & !ack_i, saturating.
//     - It clears on ack_i or in IDLE.
//     - When the count reaches TIMEOUT_CYCLES-1 with no ack: pulse m_err_o[g] for 1 cycle and go to
//       RELEASE.
//     - ack_i in the same cycle as the timeout: the ack wins and the counter clears.
//   - A master that raises CYC during another's cycle sees stall=1 and ack=0 until granted.
//   - Simultaneous release and new request: the new request is evaluated in the following IDLE
//     cycle, using the updated last.
//   - reset_i mid-cycle: everything returns to reset values in the next cycle; cyc_o drops at once.
//   - Index arithmetic uses $clog2(NUM_MASTERS) bits with explicit modulo wrap; no reliance on
//     power-of-two width.
//
// STRUCTURE
//   - Add to common_pkg:
//     - WB_MASTER_VIDEO = 0, WB_MASTER_SPI = 1, WB_MASTER_CPU = 2, WB_MASTER_COUNT = 3.
//     - WB_TIMEOUT_CYCLES = 64.
//   - Local FSM typedef: enum {IDLE, BUSY, RELEASE}.
//   - Sub-module rr_priority_arbiter: combinational; inputs req, last, priority index; output
//     one-hot grant. Unit-tested separately.
//   - The slave mux stays in this module.
//
// TESTING
//   1. Reset, then only SPI (m1) writes 8'h5A to wb_ram_addr(17'h00400).
//      -> grant_o = 3'b010 one cycle after CYC.
//      -> addr_o = 20'h00400, dout_o = 8'h5A.
//      -> m_ack_o = 3'b010 when ack_i arrives.
//   2. m1 and m2 raise CYC in the same cycle, each doing 3 back-to-back cycles.
//      -> Grants go m1, m2, m1, m2, m1, m2, with 1 idle cycle between each. There is no starvation.
//   3. m2 owns the bus doing a wb_crtc_addr(R12) read; video (m0) requests mid-cycle.
//      -> m0 stalls until m2 drops CYC, then m0 is granted ahead of a pending m1.
//   4. m1 accesses wb_io_kbd_addr(4'd3) and the slave never acks.
//      -> m_err_o[1] pulses exactly 64 cycles after the first stb_o.
//      -> cyc_o = 0 until m1 drops CYC, then the FSM returns to IDLE.
//   5. ack_i arrives on cycle 63 of the watchdog count. -> Normal ack, no err, counter cleared.
//   6. reset_i is asserted while m0 is in BUSY with stb_o high.
//      -> Next cycle: cyc_o = 0, grant_o = 0, all stall = 1, and m0 wins first after reset.

Source files
------------

// File: rtl/wb_bus_arbiter_pkg.sv
// ============================================================================
// Module  : wb_bus_arbiter_pkg
// Brief   : Shared constants and types for the Wishbone bus arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_bus_arbiter_pkg;

    localparam int WB_MASTER_VIDEO   = 0;
    localparam int WB_MASTER_SPI     = 1;
    localparam int WB_MASTER_CPU     = 2;
    localparam int WB_MASTER_COUNT   = 3;
    localparam int WB_TIMEOUT_CYCLES = 64;
    localparam int WB_ADDR_WIDTH     = 20;
    localparam int DATA_WIDTH        = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_bus_arbiter_if.sv
// ============================================================================
// Module  : wb_bus_arbiter_if
// Brief   : Per-master request bundle plus the shared slave-side Wishbone bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface wb_bus_arbiter_if
    import wb_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = WB_MASTER_COUNT
) ();

    logic [NUM_MASTERS-1:0]               m_cyc_i;
    logic [NUM_MASTERS-1:0]               m_stb_i;
    logic [NUM_MASTERS-1:0]               m_we_i;
    logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_addr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dout_i;
    logic [DATA_WIDTH-1:0]                m_din_o;
    logic [NUM_MASTERS-1:0]               m_ack_o;
    logic [NUM_MASTERS-1:0]               m_stall_o;
    logic [NUM_MASTERS-1:0]               m_err_o;
    logic                                 cyc_o;
    logic                                 stb_o;
    logic                                 we_o;
    logic [WB_ADDR_WIDTH-1:0]             addr_o;
    logic [DATA_WIDTH-1:0]                dout_o;
    logic [DATA_WIDTH-1:0]                din_i;
    logic                                 ack_i;
    logic                                 stall_i;
    logic [NUM_MASTERS-1:0]               grant_o;

    // The arbiter is the slave of the requesting masters.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dout_i, din_i, ack_i, stall_i,
        output m_din_o, m_ack_o, m_stall_o, m_err_o, cyc_o, stb_o, we_o, addr_o,
        output dout_o, grant_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dout_i, din_i, ack_i, stall_i,
        input  m_din_o, m_ack_o, m_stall_o, m_err_o, cyc_o, stb_o, we_o, addr_o,
        input  dout_o, grant_o
    );

endinterface

`default_nettype wire

// File: rtl/wb_bus_arbiter_rr.sv
// ============================================================================
// Module  : rr_priority_arbiter
// Brief   : Combinational one-hot grant: fixed priority index first, then
//           round-robin starting after the last owner.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_priority_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ),
    parameter int PRIO_W  = $clog2(NUM_REQ + 1)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_last,
    input  wire logic [PRIO_W-1:0]  i_prio,
    output logic      [NUM_REQ-1:0] o_grant
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        // An out-of-range priority index never matches, which disables priority.
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(i_prio) == k && i_req[k]) begin
                o_grant[k] = 1'b1;
                w_found    = 1'b1;
            end
        end
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = int'(i_last) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_found && w_idx == k && i_req[k]) begin
                    o_grant[k] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
// ============================================================================
// Module  : wb_bus_arbiter
// Brief   : Locks the shared Wishbone bus to one master per CYC, with video
//           priority, round-robin for the rest and an ack watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = WB_MASTER_COUNT,
    parameter int PRIORITY_MASTER = WB_MASTER_VIDEO,
    parameter int TIMEOUT_CYCLES  = WB_TIMEOUT_CYCLES
) (
    input wire logic         clock_i,
    input wire logic         reset_i,
    wb_bus_arbiter_if.slave  bus
);

    localparam int c_idx_w  = $clog2(NUM_MASTERS);
    localparam int c_prio_w = $clog2(NUM_MASTERS + 1);
    localparam int c_wdog_w = 8;
    localparam logic [c_prio_w-1:0] c_prio = c_prio_w'(PRIORITY_MASTER);

    arb_state_t               r_state, w_state_nx;
    logic [NUM_MASTERS-1:0]   r_grant, w_grant_nx, w_arb_grant;
    logic [NUM_MASTERS-1:0]   r_err, w_err_nx;
    logic [c_idx_w-1:0]       r_last, w_last_nx, w_gidx;
    logic [c_wdog_w-1:0]      r_wdog, w_wdog_nx;
    logic                     w_busy, w_gcyc, w_gstb, w_gwe, w_cyc, w_stb, w_timeout;
    logic [WB_ADDR_WIDTH-1:0] w_gaddr;
    logic [DATA_WIDTH-1:0]    w_gdout;

    rr_priority_arbiter #(
        .NUM_REQ (NUM_MASTERS)
    ) u_arb (
        .i_req   (bus.m_cyc_i),
        .i_last  (r_last),
        .i_prio  (c_prio),
        .o_grant (w_arb_grant)
    );

    always_comb begin
        w_gidx  = '0;
        w_gcyc  = 1'b0;
        w_gstb  = 1'b0;
        w_gwe   = 1'b0;
        w_gaddr = '0;
        w_gdout = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_grant[k]) begin
                w_gidx  = c_idx_w'(k);
                w_gcyc  = bus.m_cyc_i[k];
                w_gstb  = bus.m_stb_i[k];
                w_gwe   = bus.m_we_i[k];
                w_gaddr = bus.m_addr_i[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
                w_gdout = bus.m_dout_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // CYC follows the owner combinationally so a drop or a reset frees the bus at once.
    assign w_busy    = (r_state == ST_BUSY);
    assign w_cyc     = w_busy & w_gcyc & ~reset_i;
    assign w_stb     = w_cyc & w_gstb;
    assign w_timeout = w_stb & ~bus.ack_i & (r_wdog == c_wdog_w'(TIMEOUT_CYCLES - 1));

    assign bus.cyc_o     = w_cyc;
    assign bus.stb_o     = w_stb;
    assign bus.we_o      = w_cyc & w_gwe;
    assign bus.addr_o    = w_gaddr;
    assign bus.dout_o    = w_gdout;
    assign bus.m_din_o   = bus.din_i;
    assign bus.m_ack_o   = w_busy ? (r_grant & {NUM_MASTERS{bus.ack_i}}) : '0;
    assign bus.m_stall_o = w_busy ? (~r_grant | (r_grant & {NUM_MASTERS{bus.stall_i}})) : '1;
    assign bus.m_err_o   = r_err;
    assign bus.grant_o   = r_grant;

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_last_nx  = r_last;
        w_err_nx   = '0;
        w_wdog_nx  = r_wdog;
        if (!w_busy || bus.ack_i) begin
            w_wdog_nx = '0;
        end else if (w_stb && r_wdog != '1) begin
            w_wdog_nx = r_wdog + c_wdog_w'(1);
        end
        case (r_state)
            ST_IDLE: begin
                if (|bus.m_cyc_i) begin
                    w_grant_nx = w_arb_grant;
                    w_state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_gcyc) begin
                    w_last_nx  = w_gidx;
                    w_grant_nx = '0;
                    w_state_nx = ST_IDLE;
                end else if (w_timeout) begin
                    w_err_nx   = r_grant;
                    w_state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!w_gcyc) begin
                    w_last_nx  = w_gidx;
                    w_grant_nx = '0;
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_grant_nx = '0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= c_idx_w'(NUM_MASTERS - 1);
            r_err   <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_last  <= w_last_nx;
            r_err   <= w_err_nx;
            r_wdog  <= w_wdog_nx;
        end
    end

endmodule

`default_nettype wire
